digit_serial_add_sub: RTL and testbench
=======================================

# digit_serial_add_sub

Parametrised digit-serial adder/subtractor, the next generation of the team's bit-serial adder. Operands stream in LSB-first, DIGIT_W bits per beat, N_DIGITS beats per word. The block adds or subtracts per word, selected by a mode bit latched on the first digit. It reports the final carry/borrow and signed overflow on the last digit, and tolerates gaps in the input stream. It sits between a serialising front end and a digit-serial consumer; it has no back-pressure.

## Interface
- DIGIT_W, 4: bits per digit; legal range ≥1.
- N_DIGITS, 8: digits per operand word; legal range ≥1 (word width = DIGIT_W*N_DIGITS).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  digit beat present on a_digit/b_digit.
- a_digit  in  DIGIT_W  digit of operand A.
- b_digit  in  DIGIT_W  digit of operand B.
- sub  in  1  mode: 0 = A+B, 1 = A−B; sampled only on the first digit of a word.
- out_valid  out  1  result digit present.
- sum_digit  out  DIGIT_W  result digit.
- out_first  out  1  result digit is digit 0 of its word.
- out_last  out  1  result digit is digit N_DIGITS−1 of its word.
- carry_out  out  1  final carry on the last digit: add = unsigned carry, sub = 1 means no borrow; 0 on all other beats.
- ovf  out  1  two's-complement signed overflow of the word; valid on the last beat only, 0 otherwise.

## Operation
- Internal state:
  - digit counter idx, 0..N_DIGITS−1;
  - carry register;
  - latched mode register.
- The counter-based FSM has two phases:
  - IDLE/FIRST: idx==0.
  - BODY: idx>0.
- Accepted beat = in_valid==1. Non-valid cycles change no state; outputs show out_valid=0.
- On each accepted beat:
  - m = (idx==0) ? sub : latched mode.
  - c_in = (idx==0) ? m : carry register.
  - bx = b_digit XOR {DIGIT_W{m}}.
  - {c_next, s} = a_digit + bx + c_in, computed at DIGIT_W+1 bits with no truncation of c_next.
  - If idx==0, latch m into the mode register.
  - carry register ← c_next.
  - idx ← (idx==N_DIGITS−1) ? 0 : idx+1, wrapping so back-to-back words need no idle cycle.
- Overflow on the last digit only:
  - ovf = c_next XOR (carry into bit DIGIT_W−1), where the carry into the MSB comes from a_digit[DIGIT_W−2:0] + bx[DIGIT_W−2:0] + c_in.
  - For DIGIT_W==1, the carry into the MSB is c_in.
- N_DIGITS==1: every beat is both first and last. Mode and carry-in come from sub on every beat.
- A change on sub in mid-word has no effect on that word.
- Reset:
  - Asynchronously clears idx, carry, mode, and all outputs to 0.
  - A partially received word is discarded; the next accepted beat is digit 0 of a new word.

## Timing
- All outputs are registered. The result for a beat accepted at edge k appears after edge k, is stable for one cycle, and clears at edge k+1 unless another beat is accepted.
- Latency is 1 cycle; throughput is one digit per cycle. A word completes N_DIGITS accepted beats after its first beat, plus any gap cycles.
- Alignment on a valid output beat:
  - out_first reflects idx==0 at acceptance.
  - out_last reflects idx==N_DIGITS−1 at acceptance.
  - carry_out and ovf are nonzero only when out_last=1.
- Reset values: out_valid=0, sum_digit=0, out_first=0, out_last=0, carry_out=0, ovf=0.
- If rst is asserted in the same cycle as in_valid, reset wins and the beat is dropped.

## Test plan
All scenarios use DIGIT_W=4, N_DIGITS=2; digits are listed LSB first.
- Add 0x3C+0x05: A=C,3, B=5,0, sub=0 → sum digits 1,4 (0x41); out_first on beat 1, out_last on beat 2; carry_out=0, ovf=0.
- Sub 0x10−0x01: A=0,1, B=1,0, sub=1 → sum digits F,0 (0x0F); carry_out=1 (no borrow), ovf=0.
- Signed overflow, add 0x7F+0x01: A=F,7, B=1,0 → sum digits 0,8; carry_out=0, ovf=1. Sub 0x00−0x01 → sum digits F,F; carry_out=0 (borrow), ovf=0.
- Gapped input: same add as the first scenario with 3 idle cycles between the digits, and sub toggled during the gap → identical result; out_valid low during the gap.
- Back-to-back words with no idle cycle, first add then sub → counter wraps and the mode latches per word; both results are correct.
- Reset mid-word: assert rst after digit 0 → all outputs 0 immediately. A following full word computes correctly with carry-in from its own mode, showing no stale carry.

Source files
------------

// File: rtl/digit_serial_add_sub.sv
// digit_serial_add_sub: LSB-first digit-serial adder/subtractor.
// Each accepted beat carries one DIGIT_W-bit digit of operands A and B.
// The add/subtract mode is captured on digit 0 and held for the rest of
// the word. The last digit reports the final carry (or no-borrow) and the
// signed overflow. Every output is registered, giving one cycle of latency.
module digit_serial_add_sub #(
  parameter int DIGIT_W  = 4,
  parameter int N_DIGITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DIGIT_W-1:0] a_digit,
  input  logic [DIGIT_W-1:0] b_digit,
  input  logic               sub,
  output logic               out_valid,
  output logic [DIGIT_W-1:0] sum_digit,
  output logic               out_first,
  output logic               out_last,
  output logic               carry_out,
  output logic               ovf
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_ZERO = '0;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  // The word phase is derived from the digit counter, not stored separately.
  typedef enum logic {
    PH_FIRST = 1'b0,
    PH_BODY  = 1'b1
  } phase_e;

  phase_e             phase_s;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               mode_q, mode_d;
  logic               out_valid_q, out_valid_d;
  logic [DIGIT_W-1:0] sum_digit_q, sum_digit_d;
  logic               out_first_q, out_first_d;
  logic               out_last_q, out_last_d;
  logic               carry_out_q, carry_out_d;
  logic               ovf_q, ovf_d;

  logic               m_s;
  logic               c_in_s;
  logic [DIGIT_W-1:0] bx_s;
  logic [DIGIT_W:0]   sum_ext_s;
  logic               c_next_s;
  logic               c_msb_s;
  logic               last_s;

  assign phase_s = (idx_q == IDX_ZERO) ? PH_FIRST : PH_BODY;
  assign last_s  = (idx_q == IDX_LAST);

  // Select the mode and carry-in: digit 0 takes both from sub, later digits use the latched state.
  always_comb begin
    m_s    = sub;
    c_in_s = sub;
    case (phase_s)
      PH_FIRST: begin
        m_s    = sub;
        c_in_s = sub;
      end
      PH_BODY: begin
        m_s    = mode_q;
        c_in_s = carry_q;
      end
      default: begin
        m_s    = sub;
        c_in_s = sub;
      end
    endcase
  end

  assign bx_s      = b_digit ^ {DIGIT_W{m_s}};
  assign sum_ext_s = {1'b0, a_digit} + {1'b0, bx_s} + {{DIGIT_W{1'b0}}, c_in_s};
  assign c_next_s  = sum_ext_s[DIGIT_W];

  // Carry into the digit MSB is needed for the signed-overflow flag.
  generate
    if (DIGIT_W == 1) begin : g_msb_w1
      assign c_msb_s = c_in_s;
    end else begin : g_msb_wn
      logic [DIGIT_W-1:0] low_s;
      assign low_s   = {1'b0, a_digit[DIGIT_W-2:0]} + {1'b0, bx_s[DIGIT_W-2:0]}
                     + {{(DIGIT_W-1){1'b0}}, c_in_s};
      assign c_msb_s = low_s[DIGIT_W-1];
    end
  endgenerate

  // Compute the next state: only accepted beats advance; idle cycles clear the outputs.
  always_comb begin
    idx_d       = idx_q;
    carry_d     = carry_q;
    mode_d      = mode_q;
    out_valid_d = 1'b0;
    sum_digit_d = '0;
    out_first_d = 1'b0;
    out_last_d  = 1'b0;
    carry_out_d = 1'b0;
    ovf_d       = 1'b0;
    if (in_valid) begin
      if (phase_s == PH_FIRST) begin
        mode_d = m_s;
      end else begin
        mode_d = mode_q;
      end
      carry_d = c_next_s;
      if (last_s) begin
        idx_d       = IDX_ZERO;
        carry_out_d = c_next_s;
        ovf_d       = c_next_s ^ c_msb_s;
      end else begin
        idx_d       = idx_q + IDX_W'(1);
        carry_out_d = 1'b0;
        ovf_d       = 1'b0;
      end
      out_valid_d = 1'b1;
      sum_digit_d = sum_ext_s[DIGIT_W-1:0];
      out_first_d = (phase_s == PH_FIRST);
      out_last_d  = last_s;
    end else begin
      idx_d   = idx_q;
      carry_d = carry_q;
      mode_d  = mode_q;
    end
  end

  // Register the state and outputs. Reset takes priority over a beat in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= IDX_ZERO;
      carry_q     <= 1'b0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      sum_digit_q <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      sum_digit_q <= sum_digit_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      carry_out_q <= carry_out_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum_digit = sum_digit_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign carry_out = carry_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_add_sub.sv
// Bench for digit_serial_add_sub with DIGIT_W=4 and N_DIGITS=2.
// Whole-word results come from integer arithmetic and are then split into
// the digit stream the DUT should produce.
module tb_digit_serial_add_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a_digit;
  logic [3:0] b_digit;
  logic       sub;
  logic       out_valid;
  logic [3:0] sum_digit;
  logic       out_first;
  logic       out_last;
  logic       carry_out;
  logic       ovf;

  int checks = 0;
  int errs   = 0;

  digit_serial_add_sub #(.DIGIT_W(4), .N_DIGITS(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a_digit  (a_digit),
    .b_digit  (b_digit),
    .sub      (sub),
    .out_valid(out_valid),
    .sum_digit(sum_digit),
    .out_first(out_first),
    .out_last (out_last),
    .carry_out(carry_out),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Packed view of all outputs: {valid, first, last, carry, ovf, sum[3:0]}.
  function automatic logic [8:0] obs();
    return {out_valid, out_first, out_last, carry_out, ovf, sum_digit};
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Word-level reference: returns {carry, ovf, result[7:0]}.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
    int ua, ub, sa, sb, ur, sr;
    logic c, o;
    logic [7:0] r;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!s) begin
      ur = ua + ub;
      sr = sa + sb;
      c  = (ur > 255);
    end else begin
      ur = ua - ub;
      sr = sa - sb;
      c  = (ua >= ub);
    end
    o = (sr > 127) || (sr < -128);
    r = ur[7:0];
    return {c, o, r};
  endfunction

  task automatic idle(input string tag);
    in_valid = 1'b0;
    a_digit  = 4'($urandom);
    b_digit  = 4'($urandom);
    sub      = 1'($urandom);
    @(posedge clk);
    #1;
    check(tag, obs(), 9'h000);
  endtask

  task automatic beat(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic s, input logic [8:0] exp);
    in_valid = 1'b1;
    a_digit  = a;
    b_digit  = b;
    sub      = s;
    @(posedge clk);
    #1;
    check(tag, obs(), exp);
    in_valid = 1'b0;
  endtask

  task automatic run_word(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input int gap, input bit toggle);
    logic [9:0] m;
    logic [8:0] exp;
    logic       s_in;
    logic       lst;
    m = model(a, b, s);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) idle($sformatf("%s gap%0d", tag, g));
      end
      lst  = (i == 1);
      s_in = (i == 0) ? s : (toggle ? ~s : s);
      exp  = {1'b1, (i == 0), lst, lst & m[9], lst & m[8], m[4*i +: 4]};
      beat($sformatf("%s d%0d", tag, i), a[4*i +: 4], b[4*i +: 4], s_in, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a_digit  = 4'h0;
    b_digit  = 4'h0;
    sub      = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset", obs(), 9'h000);
    rst = 1'b0;
    idle("post_reset_idle");

    run_word("add_3C_05", 8'h3C, 8'h05, 1'b0, 0, 1'b0);
    run_word("sub_10_01", 8'h10, 8'h01, 1'b1, 0, 1'b0);
    run_word("add_7F_01", 8'h7F, 8'h01, 1'b0, 0, 1'b0);
    run_word("sub_00_01", 8'h00, 8'h01, 1'b1, 0, 1'b0);
    idle("idle_a");
    run_word("gap_add", 8'h3C, 8'h05, 1'b0, 3, 1'b1);
    run_word("b2b_add", 8'hA7, 8'h6C, 1'b0, 0, 1'b1);
    run_word("b2b_sub", 8'h35, 8'h9E, 1'b1, 0, 1'b1);
    run_word("b2b_sub2", 8'h80, 8'h01, 1'b1, 0, 1'b0);

    // Reset after digit 0 of 0xFF+0x01, which leaves a pending carry.
    beat("rst_word d0", 4'hF, 4'h1, 1'b0, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
    rst = 1'b1;
    #1;
    check("rst_async", obs(), 9'h000);
    in_valid = 1'b1;
    a_digit  = 4'h5;
    b_digit  = 4'h5;
    @(posedge clk);
    #1;
    check("rst_wins", obs(), 9'h000);
    in_valid = 1'b0;
    rst      = 1'b0;
    run_word("after_rst_add", 8'h3C, 8'h05, 1'b0, 0, 1'b0);
    run_word("after_rst_sub", 8'h10, 8'h01, 1'b1, 0, 1'b0);

    for (int w = 0; w < 60; w++) begin
      run_word($sformatf("rand%0d", w), 8'($urandom), 8'($urandom), 1'($urandom),
               int'($urandom_range(0, 2)), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($sformatf("rand_idle%0d", w));
    end
    idle("final_idle");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
